data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Parametrised, byte-addressed data memory for the MIPS datapath.
- Supports byte, halfword and word loads and stores, with big-endian lane mapping and sign or zero extension on loads.
- Reads are registered and each request uses a valid/ready handshake.
- Misaligned accesses are detected and flagged.
- A built-in fill engine re-initialises the whole array after reset or on command; requests stall while it runs.

Parameters:
ADDR_SIZE, 5, word-address width; depth = 2**ADDR_SIZE words of 32 bits
INIT_MODE, 1, fill pattern: 0 = all zeros, 1 = word i holds value i
INIT_ON_RESET, 1, 1 = run a fill sweep after every reset deassertion; 0 = leave array untouched by reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  ADDR_SIZE+2  byte address
req_wdata  input  32  store data, right-justified
rvalid  output  1  one-cycle pulse; rdata is valid
rdata  output  32  extended load result
err  output  1  one-cycle pulse; the accepted request was misaligned or reserved
busy  output  1  fill sweep in progress

Behaviour:
- Addressing:
  - Word index = req_addr[ADDR_SIZE+1:2]; byte offset = req_addr[1:0].
  - Big-endian: offset 0 maps to bits 31:24, offset 3 maps to bits 7:0.
  - Halfword offset 0 maps to bits 31:16, offset 2 maps to bits 15:0.
- Alignment:
  - A halfword with offset[0]=1 is misaligned.
  - A word with offset!=0 is misaligned.
  - Size 11 is always an error.
  - A misaligned access performs no write, does not update rdata and gives no rvalid. err pulses in cycle N+1.
- Store accepted in cycle N:
  - Only the addressed lanes are written at the edge ending cycle N; the other lanes are unchanged.
  - Byte store uses wdata[7:0]; halfword store uses wdata[15:0].
  - No response pulse.
- Load accepted in cycle N:
  - rvalid=1 and rdata=result in cycle N+1.
  - rdata holds its value until the next load response.
  - Full throughput: one request per cycle.
  - A store in cycle N followed by a load of the same word in N+1 returns the new data.
- Extension: a byte or halfword load is sign-extended from its MSB when req_unsigned=0, and zero-filled when req_unsigned=1.
- FSM states IDLE and FILL:
  - IDLE: req_ready=1, busy=0.
  - FILL: req_ready=0, busy=1. A fill counter runs 0 to 2**ADDR_SIZE-1, writing one word per cycle with the fill value (0, or the index when INIT_MODE=1). The state returns to IDLE in the cycle after the last word is written.
  - A sweep takes exactly 2**ADDR_SIZE cycles in FILL.
- Fill triggers:
  - Reset deassertion with INIT_ON_RESET=1: the first cycle out of reset is FILL.
  - Reset with INIT_ON_RESET=0: the first cycle is IDLE.
  - There is no command input; on-demand refill is done by pulsing rst_n.
  - The array also holds the INIT_MODE pattern at time zero, for simulation and FPGA bitstream initialisation.
- Reset values: req_ready = !INIT_ON_RESET, busy = INIT_ON_RESET, rvalid=0, err=0, rdata=0, fill counter=0.
- Reset mid-sweep restarts the sweep from word 0. Reset mid-request discards any pending response. Array contents are never cleared asynchronously.
- req_valid while req_ready=0: not accepted and no side effect. The requester holds the request until it is accepted.

Test Plan:
- Reset with INIT_ON_RESET=1, INIT_MODE=1, ADDR_SIZE=5 -> busy high for exactly 32 cycles, then req_ready=1. A word load at byte address 0x0C returns 0x00000003 with rvalid one cycle after acceptance.
- Word store of 0xA1B2C3D4 at 0x10, then back-to-back loads at 0x10 -> first load returns 0xA1B2C3D4.
  - Byte load at 0x11, signed -> 0xFFFFFFB2.
  - Halfword load at 0x12, unsigned -> 0x0000C3D4.
- Byte store of 0x7F at 0x13 over 0xA1B2C3D4 -> word reads back 0xA1B2C37F.
  - Halfword store of 0x1234 at 0x10 -> word reads back 0x1234C37F.
- Misaligned cases:
  - Word load at 0x02 -> err pulse, no rvalid, rdata unchanged.
  - Halfword store at 0x05 -> err pulse, word 1 unchanged.
  - Size 11 -> err pulse.
- Assert rst_n low at fill word 10, release -> sweep restarts at 0 and lasts a full 32 cycles. Requests are held off (req_ready=0) throughout.
- INIT_ON_RESET=0 with a stored value in word 4, then pulse reset -> req_ready=1 on the first cycle and word 4 keeps its stored value.

Source files
------------

// File: rtl/data_memory.sv
// data_memory -- byte-addressed, big-endian 32-bit data memory for the MIPS
// datapath, built from four byte-lane arrays.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid/ready   request handshake (accepted when both high)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 halfword, 10 word, 11 reserved (error)
//   req_unsigned      loads zero-extend when 1, sign-extend when 0
//   req_addr          byte address (ADDR_SIZE+2 bits)
//   req_wdata         store data, right-justified
//   rvalid/rdata      load response one cycle after acceptance; rdata holds
//   err               one-cycle pulse for a misaligned/reserved request
//   busy              fill sweep in progress (requests are stalled)
//
// Lane k holds the byte at offset k of every word, i.e. word bits
// [31-8k -: 8]. The fill engine rewrites every word after reset when
// INIT_ON_RESET is set; the arrays themselves are never reset.

// One byte lane: asynchronous read, synchronous write, preloaded with this
// lane's slice of the INIT_MODE pattern.
module data_memory_lane #(
  parameter int ADDR_SIZE = 5,
  parameter int INIT_MODE = 1,
  parameter int LANE      = 0
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);
  localparam int DEPTH = 1 << ADDR_SIZE;

  function automatic logic [DEPTH-1:0][7:0] lane_init();
    logic [DEPTH-1:0][7:0] v;
    logic [31:0]           w;
    for (int i = 0; i < DEPTH; i++) begin
      w    = (INIT_MODE != 0) ? 32'(i) : 32'd0;
      v[i] = w[31-8*LANE -: 8];
    end
    return v;
  endfunction

  // Power-up contents for simulation and bitstream initialisation.
  logic [DEPTH-1:0][7:0] mem = lane_init();

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module data_memory #(
  parameter int ADDR_SIZE     = 5,
  parameter int INIT_MODE     = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_SIZE+1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rvalid,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic                 busy
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, FILL} state_t;
  localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? FILL : IDLE;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   fill_cnt_q, fill_cnt_d;
  logic                   fill_we;

  logic [1:0]             off;
  logic [ADDR_SIZE-1:0]   word_idx, mem_addr;
  logic                   accept, misaligned, st_ok, ld_ok;
  logic [31:0]            fill_word;
  logic [NUM_LANES-1:0]   lane_sel, lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wd, lane_rd;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [31:0]            ld_word, ld_result;

  // ---------------- fill FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    req_ready  = 1'b0;
    busy       = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      FILL: begin
        busy       = 1'b1;
        fill_we    = 1'b1;
        fill_cnt_d = fill_cnt_q + 1'b1;
        // Last word written this cycle; the counter wraps to 0 on its own.
        if (&fill_cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_word = (INIT_MODE != 0) ? 32'(fill_cnt_q) : 32'd0;

  // ---------------- request decode ----------------
  assign off      = req_addr[1:0];
  assign word_idx = req_addr[ADDR_SIZE+1:2];
  assign accept   = req_valid & req_ready;
  assign mem_addr = fill_we ? fill_cnt_q : word_idx;

  always_comb begin
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  end

  assign st_ok = accept &  req_we & ~misaligned;
  assign ld_ok = accept & ~req_we & ~misaligned;

  // Lane select and write data. A halfword occupies lanes {off[1],0} and
  // {off[1],1}, the even lane taking the upper byte.
  always_comb begin
    lane_sel = '0;
    lane_we  = '0;
    lane_wd  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      case (req_size)
        2'b00:   lane_sel[k] = (off == 2'(k));
        2'b01:   lane_sel[k] = (off[1] == k[1]);
        default: lane_sel[k] = 1'b1;
      endcase
      lane_we[k] = fill_we | (st_ok & lane_sel[k]);
      if (fill_we)
        lane_wd[k] = fill_word[31-8*k -: 8];
      else begin
        case (req_size)
          2'b00:   lane_wd[k] = req_wdata[7:0];
          2'b01:   lane_wd[k] = k[0] ? req_wdata[7:0] : req_wdata[15:8];
          default: lane_wd[k] = req_wdata[31-8*k -: 8];
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    data_memory_lane #(
      .ADDR_SIZE (ADDR_SIZE),
      .INIT_MODE (INIT_MODE),
      .LANE      (k)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[k]),
      .addr  (mem_addr),
      .wdata (lane_wd[k]),
      .rdata (lane_rd[k])
    );
  end

  // ---------------- load path ----------------
  assign ld_byte = lane_rd[off];
  assign ld_half = {lane_rd[{off[1], 1'b0}], lane_rd[{off[1], 1'b1}]};
  assign ld_word = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};

  always_comb begin
    case (req_size)
      2'b00:   ld_result = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_result = {{16{~req_unsigned & ld_half[15]}}, ld_half};
      default: ld_result = ld_word;
    endcase
  end

  // A reset drops any response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= ld_ok;
      err    <= accept & misaligned;
      if (ld_ok) rdata <= ld_result;
    end
  end
endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  localparam int AS    = 5;
  localparam int DEPTH = 1 << AS;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: fill on reset
  logic        rst_n, req_valid, req_ready, req_we, req_unsigned, rvalid, err, busy;
  logic [1:0]  req_size;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata, rdata;
  // DUT B: no fill on reset
  logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_req_unsigned, b_rvalid, b_err, b_busy;
  logic [1:0]  b_req_size;
  logic [6:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_rdata;

  data_memory #(.ADDR_SIZE(AS), .INIT_MODE(1), .INIT_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rvalid(rvalid), .rdata(rdata),
    .err(err), .busy(busy));

  data_memory #(.ADDR_SIZE(AS), .INIT_MODE(1), .INIT_ON_RESET(0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rvalid(b_rvalid), .rdata(b_rdata),
    .err(b_err), .busy(b_busy));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          is_err;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  model[NB];
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a flat big-endian byte array.
  function automatic void model_fill();
    for (int i = 0; i < NB; i++) model[i] = 8'h00;
    for (int w = 0; w < DEPTH; w++) model[4*w+3] = 8'(w);
  endfunction

  function automatic bit misal(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input int a);
    logic [15:0] h;
    case (sz)
      2'd0:    return {{24{!uns && model[a][7]}}, model[a]};
      2'd1:    begin h = {model[a], model[a+1]}; return {{16{!uns && h[15]}}, h}; end
      default: return {model[a], model[a+1], model[a+2], model[a+3]};
    endcase
  endfunction

  function automatic void model_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    case (sz)
      2'd0:    model[a] = wd[7:0];
      2'd1:    begin model[a] = wd[15:8]; model[a+1] = wd[7:0]; end
      default: for (int i = 0; i < 4; i++) model[a+i] = wd[31-8*i -: 8];
    endcase
  endfunction

  // Book an accepted request (called at the negedge of its accept cycle).
  function automatic void book(input bit we, input logic [1:0] sz, input bit uns,
                               input int a, input logic [31:0] wd);
    exp_t e;
    e.at = cyc + 1;
    if (misal(sz, a)) begin
      e.is_err = 1'b1; e.data = last_rd; sb.push_back(e);
    end else if (we) begin
      model_store(sz, a, wd);
    end else begin
      last_rd = model_load(sz, uns, a);
      e.is_err = 1'b0; e.data = last_rd; sb.push_back(e);
    end
  endfunction

  // Monitor for DUT A.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() != 0 && sb[0].at < cyc) begin
        mon_e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_resp actual=none required=response_at_cycle_%0d", mon_e.at);
      end
      if (rvalid || err) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=rvalid%0b_err%0b required=no_response", rvalid, err);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(mon_e.at));
          chk("resp_err", 32'(err), 32'(mon_e.is_err));
          chk("resp_rvalid", 32'(rvalid), 32'(!mon_e.is_err));
          chk("resp_rdata", rdata, mon_e.data);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input int a,
                       input logic [31:0] wd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = 7'(a); req_wdata = wd;
    do begin @(negedge clk); n++; end while (!req_ready && n < 200);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=not_ready required=ready_within_200");
    end else book(we, sz, uns, a, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts busy cycles from the next negedge; returns at the first idle negedge.
  task automatic measure_fill(input string tag);
    int n = 0, bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (req_ready) bad++;
      n++;
    end
    chk({tag, "_ready_low"}, 32'(bad), 32'd0);
    chk({tag, "_cycles"}, 32'(n), 32'(DEPTH));
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic b_load(input int a, input logic [31:0] exp, input string name);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = 2'd2; b_req_unsigned = 1'b0;
    b_req_addr = 7'(a);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    chk({name, "_rvalid"}, 32'(b_rvalid), 32'd1);
    chk({name, "_rdata"}, b_rdata, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sz;
    int         a;
    bit         we;
    rst_n = 1'b0; b_rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_unsigned = 0; b_req_addr = 0; b_req_wdata = 0;
    model_fill(); last_rd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("b_rst_ready", 32'(b_req_ready), 32'd1);
    chk("b_rst_busy", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; b_rst_n = 1'b1;
    measure_fill("fill1");
    @(posedge clk); #1;

    // Directed cases
    issue(0, 2'd2, 0, 'h0C, 0);
    issue(1, 2'd2, 0, 'h10, 32'hA1B2C3D4);
    issue(0, 2'd2, 0, 'h10, 0);
    issue(0, 2'd0, 0, 'h11, 0);
    issue(0, 2'd1, 1, 'h12, 0);
    issue(1, 2'd0, 0, 'h13, 32'h0000007F);
    issue(0, 2'd2, 0, 'h10, 0);
    issue(1, 2'd1, 0, 'h10, 32'h00001234);
    issue(0, 2'd2, 0, 'h10, 0);
    issue(0, 2'd2, 0, 'h02, 0);
    issue(1, 2'd1, 0, 'h05, 32'hFFFFFFFF);
    issue(0, 2'd2, 0, 'h04, 0);
    issue(0, 2'd3, 0, 'h08, 0);
    issue(0, 2'd1, 0, 'h12, 0);
    issue(0, 2'd0, 1, 'h10, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(2, 0) == 0);
      sz = ($urandom_range(7, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      a  = int'($urandom_range(NB - 1, 0));
      if ($urandom_range(3, 0) != 0) begin
        if (sz == 2'd1) a = a & ~1;
        if (sz == 2'd2) a = a & ~3;
      end
      issue(we, sz, 1'($urandom_range(1, 0)), a, $urandom);
      if ($urandom_range(3, 0) == 0) idle(1);
    end
    idle(2);

    // Reset with a load response in flight, then reset again mid-sweep.
    issue(0, 2'd2, 0, 'h0C, 0);
    rst_n = 1'b0;
    sb.delete(); model_fill(); last_rd = 0;
    @(negedge clk);
    chk("rst2_rvalid", 32'(rvalid), 32'd0);
    chk("rst2_rdata", rdata, 32'd0);
    chk("rst2_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    // Store held through the whole sweep; it must land only afterwards.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 7'h14; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rst3_ready", 32'(req_ready), 32'd0);
    chk("rst3_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    measure_fill("fill2");
    book(1, 2'd2, 0, 'h14, 32'hDEADBEEF);
    @(posedge clk); #1;
    req_valid = 1'b0;
    issue(0, 2'd2, 0, 'h14, 0);
    issue(0, 2'd2, 0, 'h18, 0);
    issue(0, 2'd2, 0, 'h10, 0);
    issue(0, 2'd0, 0, 'h1F, 0);
    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // DUT B: store survives a reset, no sweep.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'd2; b_req_addr = 7'h10;
    b_req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("b_store_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    b_rst_n = 1'b0;
    @(negedge clk);
    chk("b_rst2_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    @(negedge clk);
    chk("b_first_ready", 32'(b_req_ready), 32'd1);
    chk("b_first_busy", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    b_load('h10, 32'hCAFEF00D, "b_word4");
    b_load('h14, 32'h00000005, "b_word5_init");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
